dm_abstract_ctrl: RTL

Abstract-command sequencer for the RISC-V debug module. It validates writes to the `command` register (0x17) and autoexec triggers, then drives the `abstractcs.busy` and `cmderr` fields. It generates the two-word abstract instruction buffer that the debug ROM executes ahead of the program buffer, and runs the go/going/halted/exception handshake with the selected hart. It sits between the DMI register file and the debug-memory/ROM interface, and supports 32-bit GPR Access Register commands only.

---
 rtl/dm_abstract_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/dm_abstract_ctrl.sv
// Abstract-command sequencer: validates Access Register commands, drives busy/cmderr and the
// two-word abstract buffer, and runs the go/going/done handshake. Optional: DM_ABS_POSTINC_EN.
module dm_abstract_ctrl #(
    parameter logic [11:0] DataAddr = 12'h380
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dmactive_i,
    input  logic        cmd_valid_i,
    input  logic [31:0] cmd_i,
    input  logic        autoexec_i,
    input  logic [2:0]  cmderr_clr_i,
    input  logic        hart_halted_i,
    input  logic        going_i,
    input  logic        cmd_done_i,
    input  logic        exception_i,
    output logic        go_o,
    output logic        busy_o,
    output logic [2:0]  cmderr_o,
    output logic [63:0] abs_buf_o
);
    typedef enum logic [1:0] {StIdle, StGo, StExec} state_e;

    localparam logic [2:0]  ErrNone    = 3'd0;
    localparam logic [2:0]  ErrBusy    = 3'd1;
    localparam logic [2:0]  ErrNotSup  = 3'd2;
    localparam logic [2:0]  ErrExc     = 3'd3;
    localparam logic [2:0]  ErrHalt    = 3'd4;
    localparam logic [31:0] InsnNop    = 32'h0000_0013;
    localparam logic [31:0] InsnEbreak = 32'h0010_0073;

    state_e      r_state, w_state_d;
    logic [31:0] r_cmd, w_cmd_d, w_cmd_eff;
    logic [2:0]  r_cmderr, w_cmderr_d, w_cmderr_clr, w_err_new;
    logic [63:0] r_abs_buf, w_abs_buf_d;
    logic [31:0] w_word0, w_word1;
    logic        w_trig, w_unsup_type, w_unsup_reg;

    assign w_trig    = cmd_valid_i | autoexec_i;
    assign w_cmd_eff = cmd_valid_i ? cmd_i : r_cmd;

`ifdef DM_ABS_POSTINC_EN
    assign w_unsup_type = (w_cmd_eff[31:24] != 8'h00) || (w_cmd_eff[22:20] != 3'd2);
`else
    assign w_unsup_type = (w_cmd_eff[31:24] != 8'h00) || (w_cmd_eff[22:20] != 3'd2) ||
                          w_cmd_eff[19];
`endif
    assign w_unsup_reg  = w_cmd_eff[17] &&
                          ((w_cmd_eff[15:0] < 16'h1000) || (w_cmd_eff[15:0] > 16'h101F));

    // Clear is applied before any new error so a same-cycle error can land.
    assign w_cmderr_clr = r_cmderr & ~cmderr_clr_i;

    always_comb begin
        w_state_d = r_state;
        w_cmd_d   = r_cmd;
        w_err_new = ErrNone;
        unique case (r_state)
            StGo: begin
                if (going_i) w_state_d = StExec;
            end
            StExec: begin
                if (exception_i) begin
                    w_state_d = StIdle;
                    w_err_new = ErrExc;
                end else if (cmd_done_i) begin
                    w_state_d = StIdle;
`ifdef DM_ABS_POSTINC_EN
                    if (r_cmd[19]) w_cmd_d[15:0] = r_cmd[15:0] + 16'd1;
`endif
                end
            end
            default: ;
        endcase
        if (w_trig) begin
            if (r_state != StIdle) begin
                if (w_err_new == ErrNone) w_err_new = ErrBusy;
            end else begin
                if (cmd_valid_i) w_cmd_d = cmd_i;
                if (r_cmderr == ErrNone) begin
                    if (w_unsup_type || w_unsup_reg) w_err_new = ErrNotSup;
                    else if (!hart_halted_i)         w_err_new = ErrHalt;
                    else                             w_state_d = StGo;
                end
            end
        end
        w_cmderr_d = (w_cmderr_clr == ErrNone) ? w_err_new : w_cmderr_clr;
    end

    always_comb begin
        w_word0 = InsnNop;
        if (w_cmd_d[17]) begin
            if (w_cmd_d[16]) w_word0 = {DataAddr, 5'd0, 3'b010, w_cmd_d[4:0], 7'b0000011};
            else w_word0 = {DataAddr[11:5], w_cmd_d[4:0], 5'd0, 3'b010, DataAddr[4:0],
                            7'b0100011};
        end
        w_word1     = w_cmd_d[18] ? InsnNop : InsnEbreak;
        w_abs_buf_d = {w_word1, w_word0};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !dmactive_i) begin
            r_state   <= StIdle;
            r_cmd     <= 32'h0;
            r_cmderr  <= ErrNone;
            r_abs_buf <= {InsnEbreak, InsnNop};
        end else begin
            r_state   <= w_state_d;
            r_cmd     <= w_cmd_d;
            r_cmderr  <= w_cmderr_d;
            r_abs_buf <= w_abs_buf_d;
        end
    end

    assign go_o      = (r_state == StGo);
    assign busy_o    = (r_state != StIdle);
    assign cmderr_o  = r_cmderr;
    assign abs_buf_o = r_abs_buf;
endmodule
